mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter DATA_W, 32, data and address width.
REQ-002 Parameter REG_ADDR_W, 5, register address width.
REQ-003 Parameter TIMEOUT, 255, max BUSY cycles awaiting bus_ack (range 2..255).
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 reset_  in  1  asynchronous, active-high reset.
REQ-006 mem_read_ex / mem_write_ex  in  1 each  load / store request from EX/MEM register.
REQ-007 mem_size_ex  in  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-008 mem_signed_ex  in  1  1 sign-extends loads, 0 zero-extends.
REQ-009 mem_to_reg_ex, reg_write_ex  in  1 each  writeback controls.
REQ-010 alu_out_ex  in  DATA_W  effective address or ALU result; store_data_ex  in  DATA_W.
REQ-011 dst_addr_ex  in  REG_ADDR_W  destination register.
REQ-012 bus_req, bus_we  out  1  registered request / write strobe to data memory.
REQ-013 bus_addr  out  DATA_W  registered word-aligned address (bits [1:0] = 0).
REQ-014 bus_be  out  4  registered byte enables; bus_wdata  out  DATA_W  registered.
REQ-015 bus_rdata  in  DATA_W; bus_ack  in  1  one-cycle completion pulse.
REQ-016 stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM while high.
REQ-017 misalign, bus_error  out  1 each  single-cycle exception pulses.
REQ-018 mem_to_reg_mem, reg_write_mem  out  1; addr_mem, dout_mem  out  DATA_W; dst_addr_mem  out  REG_ADDR_W  to MEM/WB register.

Function
REQ-019 FSM states IDLE, BUSY; access = (mem_read_ex | mem_write_ex) & aligned.
REQ-020 aligned: byte always; half needs alu_out_ex[0]=0; word needs alu_out_ex[1:0]=00.
REQ-021 IDLE, no access: outputs pass through combinationally (addr_mem=alu_out_ex, dout_mem=0, controls and dst unchanged), stall=0.
REQ-022 IDLE, access: stall=1, reg_write_mem=0, mem_to_reg_mem=0; next edge loads bus_* registers, bus_req<=1, counter<=0, state<=BUSY.
REQ-023 Both read and write asserted: treated as write (bus_we=1, reg_write_mem forced 0 on completion).
REQ-024 Store lanes: byte replicated x4, bus_be = 1<<addr[1:0]; half replicated x2, bus_be = 0011 (addr[1]=0) or 1100; word bus_be=1111. Loads: bus_be=1111, bus_wdata=0.
REQ-025 BUSY, bus_ack=0: stall=1, bubble outputs as REQ-022, counter increments.
REQ-026 BUSY, bus_ack=1: stall=0 that cycle; outputs = EX inputs with dout_mem = formatted load data (0 for stores); next edge bus_req<=0, state<=IDLE.
REQ-027 Load format: lane = addr[1:0], byte k = bus_rdata[8k+7:8k] little-endian; half from lanes {addr[1],1}:{addr[1],0}; extend per mem_signed_ex to DATA_W.
REQ-028 BUSY, counter = TIMEOUT-1 and no ack: bus_error=1, stall=0, reg_write_mem=0, next edge bus_req<=0, state<=IDLE.
REQ-029 Ack on the same cycle as timeout: ack wins, bus_error=0.
REQ-030 Misaligned access in IDLE: misalign=1 that cycle, no bus request, stall=0, reg_write_mem=0, mem_to_reg_mem=0.
REQ-031 bus_ack while IDLE ignored; bus_req never asserted more than one transaction at a time.
REQ-032 EX inputs held stable by upstream while stall=1; block does not re-register them.

Reset
REQ-033 reset_ high: state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, counter=0, immediately without clk.
REQ-034 Reset in BUSY aborts transaction; bus_req drops asynchronously; no writeback, no exception pulse.
REQ-035 Combinational outputs after reset follow REQ-021 from current inputs.

Verification
REQ-036 LW addr 0x104, ack 2 cycles after bus_req -> bus_addr 0x104, be 1111, stall high 3 cycles, dout_mem = bus_rdata, reg_write_mem=1 on ack cycle.
REQ-037 LB signed addr 0x103, rdata 0x80FF_0000 -> dout_mem 0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-038 SH addr 0x202, data 0x1234_ABCD -> bus_be 1100, bus_wdata 0xABCD_ABCD, bus_we=1, reg_write_mem=0.
REQ-039 LW addr 0x102 -> misalign pulse 1 cycle, bus_req stays 0, stall 0.
REQ-040 Load, no ack, TIMEOUT=4 -> bus_error on 4th BUSY cycle, bus_req low next cycle, FSM IDLE.
REQ-041 reset_ asserted mid-BUSY -> bus_req 0 same cycle, all registers zero, next LW completes normally.

Source files
------------

// File: rtl/mem_access.sv
// Memory-stage access unit: turns EX/MEM load/store requests into single
// outstanding data-bus transactions, stalls the pipeline and formats load data.
module mem_access #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  mem_read_ex,
  input  logic                  mem_write_ex,
  input  logic [1:0]            mem_size_ex,
  input  logic                  mem_signed_ex,
  input  logic                  mem_to_reg_ex,
  input  logic                  reg_write_ex,
  input  logic [DATA_W-1:0]     alu_out_ex,
  input  logic [DATA_W-1:0]     store_data_ex,
  input  logic [REG_ADDR_W-1:0] dst_addr_ex,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [DATA_W-1:0]     bus_addr,
  output logic [3:0]            bus_be,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic [DATA_W-1:0]     bus_rdata,
  input  logic                  bus_ack,
  output logic                  stall,
  output logic                  misalign,
  output logic                  bus_error,
  output logic                  mem_to_reg_mem,
  output logic                  reg_write_mem,
  output logic [DATA_W-1:0]     addr_mem,
  output logic [DATA_W-1:0]     dout_mem,
  output logic [REG_ADDR_W-1:0] dst_addr_mem
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg;
  logic [7:0]  count_reg;

  logic        mem_req;
  logic        aligned;
  logic        access;
  logic        timeout;
  logic [1:0]  lane;
  logic [3:0]  be_next;
  logic [DATA_W-1:0] wdata_next;
  logic [DATA_W-1:0] load_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [7:0]  rd_bytes [4];

  assign lane    = alu_out_ex[1:0];
  assign mem_req = mem_read_ex | mem_write_ex;
  assign access  = mem_req & aligned;
  assign timeout = (count_reg == COUNT_LAST);

  always_comb begin
    case (mem_size_ex)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~lane[0];
      default: aligned = (lane == 2'b00);
    endcase
  end

  // Little-endian byte lanes of the read bus.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lanes
    assign rd_bytes[gi] = bus_rdata[8*gi +: 8];
  end

  assign ld_byte = rd_bytes[lane];
  assign ld_half = {rd_bytes[{lane[1], 1'b1}], rd_bytes[{lane[1], 1'b0}]};

  always_comb begin
    case (mem_size_ex)
      2'b00:   load_data = mem_signed_ex ? {{(DATA_W-8){ld_byte[7]}}, ld_byte}
                                         : {{(DATA_W-8){1'b0}}, ld_byte};
      2'b01:   load_data = mem_signed_ex ? {{(DATA_W-16){ld_half[15]}}, ld_half}
                                         : {{(DATA_W-16){1'b0}}, ld_half};
      default: load_data = bus_rdata;
    endcase
  end

  // Stores replicate the datum across every lane so memory only needs bus_be.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = '0;
    if (mem_write_ex) begin
      case (mem_size_ex)
        2'b00: begin
          be_next    = 4'b0001 << lane;
          wdata_next = {(DATA_W/8){store_data_ex[7:0]}};
        end
        2'b01: begin
          be_next    = lane[1] ? 4'b1100 : 4'b0011;
          wdata_next = {(DATA_W/16){store_data_ex[15:0]}};
        end
        default: wdata_next = store_data_ex;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      state_reg <= IDLE;
      count_reg <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (access) begin
            state_reg <= BUSY;
            count_reg <= '0;
            bus_req   <= 1'b1;
            bus_we    <= mem_write_ex;
            bus_addr  <= {alu_out_ex[DATA_W-1:2], 2'b00};
            bus_be    <= be_next;
            bus_wdata <= wdata_next;
          end
        end
        BUSY: begin
          if (bus_ack || timeout) begin
            state_reg <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
          end else begin
            count_reg <= count_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall          = 1'b0;
    misalign       = 1'b0;
    bus_error      = 1'b0;
    mem_to_reg_mem = mem_to_reg_ex;
    reg_write_mem  = reg_write_ex;
    addr_mem       = alu_out_ex;
    dout_mem       = '0;
    dst_addr_mem   = dst_addr_ex;
    case (state_reg)
      IDLE: begin
        if (access) begin
          stall          = 1'b1;
          reg_write_mem  = 1'b0;
          mem_to_reg_mem = 1'b0;
        end else if (mem_req) begin
          misalign       = 1'b1;
          reg_write_mem  = 1'b0;
          mem_to_reg_mem = 1'b0;
        end
      end
      BUSY: begin
        if (bus_ack) begin
          // A combined read+write request completes as a store: no writeback.
          dout_mem      = mem_write_ex ? '0 : load_data;
          reg_write_mem = reg_write_ex & ~mem_write_ex;
        end else if (timeout) begin
          bus_error      = 1'b1;
          reg_write_mem  = 1'b0;
          mem_to_reg_mem = 1'b0;
        end else begin
          stall          = 1'b1;
          reg_write_mem  = 1'b0;
          mem_to_reg_mem = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: table of load/store transactions plus
// hand-written reset, idle, timeout and abort sequences.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset_;
  logic        mem_read_ex, mem_write_ex, mem_signed_ex, mem_to_reg_ex, reg_write_ex;
  logic [1:0]  mem_size_ex;
  logic [31:0] alu_out_ex, store_data_ex, bus_rdata;
  logic [4:0]  dst_addr_ex;
  logic        bus_ack;
  logic        bus_req, bus_we, stall, misalign, bus_error, mem_to_reg_mem, reg_write_mem;
  logic [31:0] bus_addr, bus_wdata, addr_mem, dout_mem;
  logic [3:0]  bus_be;
  logic [4:0]  dst_addr_mem;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access #(.DATA_W(32), .REG_ADDR_W(5), .TIMEOUT(4)) dut (
    .clk(clk), .reset_(reset_),
    .mem_read_ex(mem_read_ex), .mem_write_ex(mem_write_ex),
    .mem_size_ex(mem_size_ex), .mem_signed_ex(mem_signed_ex),
    .mem_to_reg_ex(mem_to_reg_ex), .reg_write_ex(reg_write_ex),
    .alu_out_ex(alu_out_ex), .store_data_ex(store_data_ex), .dst_addr_ex(dst_addr_ex),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .stall(stall), .misalign(misalign), .bus_error(bus_error),
    .mem_to_reg_mem(mem_to_reg_mem), .reg_write_mem(reg_write_mem),
    .addr_mem(addr_mem), .dout_mem(dout_mem), .dst_addr_mem(dst_addr_mem)
  );

  typedef struct {
    logic        rd, wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr, sdata, rdata;
    int          delay;
    logic        exp_mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_baddr, exp_wdata, exp_dout;
    logic        exp_rw;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic rd, logic wr, logic [1:0] size, logic sgn,
                              logic [31:0] addr, logic [31:0] sdata, logic [31:0] rdata,
                              int delay, logic mis, logic [3:0] be, logic [31:0] baddr,
                              logic [31:0] wdata, logic [31:0] dout, logic rw);
    vec_t v;
    v.rd = rd; v.wr = wr; v.size = size; v.sgn = sgn;
    v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.delay = delay;
    v.exp_mis = mis; v.exp_be = be; v.exp_baddr = baddr;
    v.exp_wdata = wdata; v.exp_dout = dout; v.exp_rw = rw;
    return v;
  endfunction

  task automatic clear_inputs();
    mem_read_ex = 1'b0; mem_write_ex = 1'b0; mem_size_ex = 2'b00; mem_signed_ex = 1'b0;
    mem_to_reg_ex = 1'b0; reg_write_ex = 1'b0; alu_out_ex = '0; store_data_ex = '0;
    dst_addr_ex = '0; bus_rdata = '0; bus_ack = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+2 of the cycle after completion.
  task automatic run_vec(input int idx, input vec_t v);
    int stalls;
    mem_read_ex = v.rd; mem_write_ex = v.wr; mem_size_ex = v.size; mem_signed_ex = v.sgn;
    reg_write_ex = v.rd; mem_to_reg_ex = v.rd; alu_out_ex = v.addr; store_data_ex = v.sdata;
    dst_addr_ex = 5'(idx + 1); bus_ack = 1'b0;
    #1;
    chk($sformatf("v%0d_misalign", idx), 32'(misalign), 32'(v.exp_mis));
    chk($sformatf("v%0d_rw_issue", idx), 32'(reg_write_mem), 32'd0);
    if (v.exp_mis) begin
      chk($sformatf("v%0d_stall_mis", idx), 32'(stall), 32'd0);
      chk($sformatf("v%0d_m2r_mis", idx), 32'(mem_to_reg_mem), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_req_mis", idx), 32'(bus_req), 32'd0);
      clear_inputs();
      $display("vec %0d: misaligned access addr %h", idx, v.addr);
      return;
    end
    stalls = int'(stall);
    @(posedge clk); #1;
    chk($sformatf("v%0d_req", idx), 32'(bus_req), 32'd1);
    chk($sformatf("v%0d_we", idx), 32'(bus_we), 32'(v.wr));
    chk($sformatf("v%0d_addr", idx), bus_addr, v.exp_baddr);
    chk($sformatf("v%0d_be", idx), 32'(bus_be), 32'(v.exp_be));
    chk($sformatf("v%0d_wdata", idx), bus_wdata, v.exp_wdata);
    for (int k = 0; k < v.delay; k++) begin
      stalls += int'(stall);
      chk($sformatf("v%0d_err_wait", idx), 32'(bus_error), 32'd0);
      @(posedge clk); #1;
    end
    bus_ack = 1'b1; bus_rdata = v.rdata;
    #1;
    chk($sformatf("v%0d_stall_ack", idx), 32'(stall), 32'd0);
    chk($sformatf("v%0d_err_ack", idx), 32'(bus_error), 32'd0);
    chk($sformatf("v%0d_dout", idx), dout_mem, v.exp_dout);
    chk($sformatf("v%0d_rw", idx), 32'(reg_write_mem), 32'(v.exp_rw));
    chk($sformatf("v%0d_addr_mem", idx), addr_mem, v.addr);
    chk($sformatf("v%0d_stall_cycles", idx), 32'(stalls), 32'(v.delay + 1));
    @(posedge clk); #1;
    clear_inputs();
    #1;
    chk($sformatf("v%0d_req_done", idx), 32'(bus_req), 32'd0);
    $display("vec %0d: addr %h be %b wdata %h dout %h", idx, v.addr, v.exp_be, v.exp_wdata, v.exp_dout);
  endtask

  initial begin
    vecs[0]  = mk(1,0,2'b10,0,32'h104,0,32'hDEADBEEF,2,0,4'hF,32'h104,0,32'hDEADBEEF,1);
    vecs[1]  = mk(1,0,2'b00,1,32'h103,0,32'h80FF0000,1,0,4'hF,32'h100,0,32'hFFFFFF80,1);
    vecs[2]  = mk(1,0,2'b00,0,32'h103,0,32'h80FF0000,0,0,4'hF,32'h100,0,32'h00000080,1);
    vecs[3]  = mk(0,1,2'b01,0,32'h202,32'h1234ABCD,0,1,0,4'hC,32'h200,32'hABCDABCD,0,0);
    vecs[4]  = mk(1,0,2'b10,0,32'h102,0,0,0,1,4'h0,0,0,0,0);
    vecs[5]  = mk(0,1,2'b00,0,32'h101,32'h000000A5,0,0,0,4'h2,32'h100,32'hA5A5A5A5,0,0);
    vecs[6]  = mk(1,0,2'b01,1,32'h106,0,32'h80017FFF,1,0,4'hF,32'h104,0,32'hFFFF8001,1);
    vecs[7]  = mk(1,0,2'b01,0,32'h104,0,32'h80017FFF,0,0,4'hF,32'h104,0,32'h00007FFF,1);
    vecs[8]  = mk(1,0,2'b01,0,32'h105,0,0,0,1,4'h0,0,0,0,0);
    vecs[9]  = mk(1,0,2'b00,1,32'h105,0,32'h00007F00,3,0,4'hF,32'h104,0,32'h0000007F,1);
    vecs[10] = mk(0,1,2'b10,0,32'h300,32'hCAFEF00D,0,2,0,4'hF,32'h300,32'hCAFEF00D,0,0);
    vecs[11] = mk(1,1,2'b10,0,32'h10C,32'h11223344,32'h99999999,1,0,4'hF,32'h10C,32'h11223344,0,0);
    vecs[12] = mk(1,0,2'b11,0,32'h108,0,32'h55AA55AA,0,0,4'hF,32'h108,0,32'h55AA55AA,1);
    vecs[13] = mk(0,1,2'b11,0,32'h30A,32'h1,0,0,1,4'h0,0,0,0,0);
    vecs[14] = mk(0,1,2'b00,0,32'h303,32'h12345678,0,1,0,4'h8,32'h300,32'h78787878,0,0);

    clear_inputs();
    reset_ = 1'b1;
    #2;
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_be", 32'(bus_be), 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    @(posedge clk); #1;
    reset_ = 1'b0;

    // Idle pass-through with a stray ack that must be ignored.
    reg_write_ex = 1'b1; mem_to_reg_ex = 1'b1; alu_out_ex = 32'hABCD0123;
    dst_addr_ex = 5'h13; bus_ack = 1'b1;
    #1;
    chk("idle_addr_mem", addr_mem, 32'hABCD0123);
    chk("idle_dout", dout_mem, 32'd0);
    chk("idle_rw", 32'(reg_write_mem), 32'd1);
    chk("idle_m2r", 32'(mem_to_reg_mem), 32'd1);
    chk("idle_dst", 32'(dst_addr_mem), 32'h13);
    chk("idle_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk("idle_ack_req", 32'(bus_req), 32'd0);
    clear_inputs();
    $display("idle pass-through with stray ack");

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Load with no ack: error on the 4th BUSY cycle.
    mem_read_ex = 1'b1; mem_size_ex = 2'b10; reg_write_ex = 1'b1; mem_to_reg_ex = 1'b1;
    alu_out_ex = 32'h110;
    @(posedge clk); #1;
    chk("to_req", 32'(bus_req), 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("to_err_c%0d", k), 32'(bus_error), 32'd0);
      chk($sformatf("to_stall_c%0d", k), 32'(stall), 32'd1);
      @(posedge clk); #1;
    end
    chk("to_err", 32'(bus_error), 32'd1);
    chk("to_stall", 32'(stall), 32'd0);
    chk("to_rw", 32'(reg_write_mem), 32'd0);
    @(posedge clk); #1;
    chk("to_req_drop", 32'(bus_req), 32'd0);
    clear_inputs();
    #1;
    chk("to_err_pulse", 32'(bus_error), 32'd0);
    chk("to_idle_stall", 32'(stall), 32'd0);
    $display("timeout sequence addr 00000110");

    // Reset in the middle of a transaction.
    mem_read_ex = 1'b1; mem_size_ex = 2'b10; reg_write_ex = 1'b1; alu_out_ex = 32'h120;
    @(posedge clk); #1;
    chk("ab_req", 32'(bus_req), 32'd1);
    reset_ = 1'b1;
    #1;
    chk("ab_req_drop", 32'(bus_req), 32'd0);
    chk("ab_addr", bus_addr, 32'd0);
    chk("ab_be", 32'(bus_be), 32'd0);
    chk("ab_err", 32'(bus_error), 32'd0);
    clear_inputs();
    @(posedge clk); #1;
    reset_ = 1'b0;
    $display("reset abort mid-transaction");
    run_vec(15, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
